input_capture: RTL and testbench



---
 rtl/input_capture_if.sv | 12 +
 rtl/input_capture.sv | 93 +++++++++
 tb/tb_input_capture.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/input_capture_if.sv
// input_capture_if: switch/enable inputs and colour/status outputs of the player-input front end
interface input_capture_if;
  logic       enable;
  logic [3:0] sw;
  logic [1:0] colour_o;
  logic       colour_valid;
  logic       invalid_o;
  logic       timeout_o;
  logic       busy;
  modport master (output enable, sw, input colour_o, colour_valid, invalid_o, timeout_o, busy);
  modport slave (input enable, sw, output colour_o, colour_valid, invalid_o, timeout_o, busy);
endinterface

// File: rtl/input_capture.sv
// input_capture: synchronises and debounces four colour switches into single-cycle colour/invalid/timeout pulses
module input_capture #(
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int TIMEOUT_CYCLES  = 250_000_000
) (
  input logic             clk,
  input logic             reset,
  input_capture_if.slave  bus
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [DW-1:0] D_LOAD = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] T_LOAD = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0] IDLE         = 3'd0;
  localparam logic [2:0] WAIT_PRESS   = 3'd1;
  localparam logic [2:0] DEBOUNCE     = 3'd2;
  localparam logic [2:0] WAIT_RELEASE = 3'd3;
  localparam logic [2:0] LOCKED       = 3'd4;
  logic [2:0]    state;
  logic [3:0]    s1, s_sw, pat;
  logic [DW-1:0] dcnt;
  logic [TW-1:0] tcnt;
  logic          one_hot;
  logic [1:0]    enc;
  assign one_hot  = (pat != 4'd0) && ((pat & (pat - 4'd1)) == 4'd0);
  assign enc      = {pat[3] | pat[2], pat[3] | pat[1]};
  assign bus.busy = (state == DEBOUNCE) || (state == WAIT_RELEASE);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      s1               <= '0;
      s_sw             <= '0;
      pat              <= '0;
      dcnt             <= '0;
      tcnt             <= '0;
      bus.colour_o     <= '0;
      bus.colour_valid <= 1'b0;
      bus.invalid_o    <= 1'b0;
      bus.timeout_o    <= 1'b0;
    end else begin
      s1               <= bus.sw;
      s_sw             <= s1;
      bus.colour_valid <= 1'b0;
      bus.invalid_o    <= 1'b0;
      bus.timeout_o    <= 1'b0;
      // dropping enable abandons whatever is in flight, including a pulse due this cycle
      if (!bus.enable) state <= IDLE;
      else begin
        case (state)
          IDLE: begin
            state <= WAIT_PRESS;
            tcnt  <= T_LOAD;
          end
          WAIT_PRESS: begin
            if (s_sw != 4'd0) begin
              pat   <= s_sw;
              dcnt  <= D_LOAD;
              state <= DEBOUNCE;
            end else if (tcnt == '0) begin
              bus.timeout_o <= 1'b1;
              state         <= LOCKED;
            end else tcnt <= tcnt - TW'(1);
          end
          DEBOUNCE: begin
            if (s_sw != pat) begin
              pat  <= s_sw;
              dcnt <= D_LOAD;
              if (s_sw == 4'd0) state <= WAIT_PRESS;
            end else if (dcnt != '0) dcnt <= dcnt - DW'(1);
            else begin
              if (one_hot) begin
                bus.colour_valid <= 1'b1;
                bus.colour_o     <= enc;
              end else bus.invalid_o <= 1'b1;
              dcnt  <= D_LOAD;
              state <= WAIT_RELEASE;
            end
          end
          WAIT_RELEASE: begin
            if (s_sw != 4'd0) dcnt <= D_LOAD;
            else if (dcnt != '0) dcnt <= dcnt - DW'(1);
            else begin
              state <= WAIT_PRESS;
              tcnt  <= T_LOAD;
            end
          end
          LOCKED: ;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_input_capture.sv
// tb_input_capture: directed literal checks plus randomized stimulus against a count-up behavioural model
module tb_input_capture;
  localparam int D = 4;
  localparam int T = 20;
  logic clk = 1'b0;
  logic reset = 1'b1;
  input_capture_if bus();
  input_capture #(.DEBOUNCE_CYCLES(D), .TIMEOUT_CYCLES(T)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  int checks = 0;
  int failures = 0;
  int e = 0;
  // model: mode 0 idle, 1 armed, 2 pressing, 3 releasing, 4 locked; all run lengths count upward
  int         m_mode = 0, waited = 0, stable = 0, zeros = 0;
  logic [3:0] hist[2] = '{4'd0, 4'd0};
  logic [3:0] m_pat = 4'd0, ssw;
  logic [1:0] m_col = 2'd0;
  logic       m_cv = 1'b0, m_inv = 1'b0, m_to = 1'b0;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_mode = 0; waited = 0; stable = 0; zeros = 0; m_pat = 4'd0;
      hist[0] = 4'd0; hist[1] = 4'd0;
      m_col = 2'd0; m_cv = 1'b0; m_inv = 1'b0; m_to = 1'b0;
    end else begin
      ssw = hist[0];
      hist[0] = hist[1];
      hist[1] = bus.sw;
      m_cv = 1'b0; m_inv = 1'b0; m_to = 1'b0;
      if (!bus.enable) m_mode = 0;
      else if (m_mode == 0) begin
        m_mode = 1; waited = 0;
      end else if (m_mode == 1) begin
        if (ssw != 0) begin
          m_mode = 2; m_pat = ssw; stable = 0;
        end else begin
          waited++;
          if (waited == T) begin m_to = 1'b1; m_mode = 4; end
        end
      end else if (m_mode == 2) begin
        if (ssw != m_pat) begin
          m_pat = ssw; stable = 0;
          if (ssw == 0) m_mode = 1;
        end else begin
          stable++;
          if (stable == D) begin
            if ($countones(m_pat) == 1) begin
              m_cv = 1'b1;
              for (int k = 0; k < 4; k++) if (m_pat[k]) m_col = 2'(k);
            end else m_inv = 1'b1;
            m_mode = 3; zeros = 0;
          end
        end
      end else if (m_mode == 3) begin
        zeros = (ssw == 0) ? zeros + 1 : 0;
        if (zeros == D) begin m_mode = 1; waited = 0; end
      end
    end
  end
  always @(negedge clk) begin
    checks++;
    if ({bus.colour_o, bus.colour_valid, bus.invalid_o, bus.timeout_o, bus.busy} !==
        {m_col, m_cv, m_inv, m_to, (m_mode == 2 || m_mode == 3)}) begin
      failures++;
      $display("FAIL model_cmp t=%0t got col=%0d cv=%b inv=%b to=%b busy=%b exp col=%0d cv=%b inv=%b to=%b busy=%b",
               $time, bus.colour_o, bus.colour_valid, bus.invalid_o, bus.timeout_o, bus.busy,
               m_col, m_cv, m_inv, m_to, (m_mode == 2 || m_mode == 3));
    end
  end
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask
  task automatic start(input logic en, input logic [3:0] s);
    @(posedge clk);
    #2 bus.enable = en; bus.sw = s; e = 0;
  endtask
  task automatic step();
    @(posedge clk);
    #1 e++;
  endtask
  task automatic set_in(input logic en, input logic [3:0] s);
    #1 bus.enable = en; bus.sw = s;
  endtask
  task automatic settle();
    set_in(1'b0, 4'd0);
    repeat (6) step();
  endtask
  int pulses;
  initial begin
    bus.enable = 1'b0;
    bus.sw = 4'd0;
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;
    chk("reset_outputs", {bus.colour_o, bus.colour_valid, bus.invalid_o, bus.timeout_o, bus.busy}, 0);
    start(1'b1, 4'b0100);
    for (int i = 1; i <= 9; i++) begin
      step();
      if (i == 2) chk("A_busy_e2", bus.busy, 0);
      if (i == 3) chk("A_busy_e3", bus.busy, 1);
      if (i == 6) chk("A_cv_e6", bus.colour_valid, 0);
      if (i == 6) chk("A_busy_e6", bus.busy, 1);
      if (i == 7) chk("A_cv_e7", bus.colour_valid, 1);
      if (i == 7) chk("A_col_e7", bus.colour_o, 2);
      if (i == 8) chk("A_cv_e8", bus.colour_valid, 0);
    end
    settle();
    start(1'b1, 4'b0010);
    pulses = 0;
    for (int i = 1; i <= 16; i++) begin
      step();
      if (i <= 14) pulses += int'(bus.colour_valid);
      if (i == 14) chk("B_no_pulse_bounce", pulses, 0);
      if (i == 15) chk("B_cv_e15", bus.colour_valid, 1);
      if (i == 15) chk("B_col_e15", bus.colour_o, 1);
      if (i == 2 || i == 6) set_in(1'b1, 4'b0000);
      if (i == 4 || i == 8) set_in(1'b1, 4'b0010);
    end
    settle();
    start(1'b1, 4'b1001);
    pulses = 0;
    for (int i = 1; i <= 9; i++) begin
      step();
      pulses += int'(bus.colour_valid);
      if (i == 6) chk("C_inv_e6", bus.invalid_o, 0);
      if (i == 7) chk("C_inv_e7", bus.invalid_o, 1);
      if (i == 7) chk("C_col_held", bus.colour_o, 1);
    end
    chk("C_no_cv", pulses, 0);
    settle();
    start(1'b1, 4'd0);
    pulses = 0;
    for (int i = 1; i <= 50; i++) begin
      step();
      if (i == 20) chk("D_to_e20", bus.timeout_o, 0);
      if (i == 21) chk("D_to_e21", bus.timeout_o, 1);
      if (i > 21) pulses += int'(bus.timeout_o);
    end
    chk("D_locked_no_retrigger", pulses, 0);
    set_in(1'b0, 4'd0);
    repeat (2) step();
    start(1'b1, 4'd0);
    pulses = 0;
    for (int i = 1; i <= 21; i++) begin
      step();
      pulses += int'(bus.timeout_o);
    end
    chk("D_rearm_to_e21", bus.timeout_o, 1);
    chk("D_rearm_count", pulses, 1);
    settle();
    start(1'b1, 4'b0001);
    pulses = 0;
    for (int i = 1; i <= 50; i++) begin
      step();
      pulses += int'(bus.colour_valid);
      if (i == 7) chk("E_col_e7", bus.colour_o, 0);
      if (i == 7) chk("E_cv_e7", bus.colour_valid, 1);
    end
    set_in(1'b1, 4'b1000);
    repeat (20) begin step(); pulses += int'(bus.colour_valid); end
    chk("E_one_cv_no_release", pulses, 1);
    set_in(1'b1, 4'b0000);
    repeat (8) step();
    set_in(1'b1, 4'b1000);
    pulses = 0;
    for (int i = 1; i <= 7; i++) begin
      step();
      if (i < 7) pulses += int'(bus.colour_valid);
    end
    chk("E_early_cv", pulses, 0);
    chk("E_cv_after_release", bus.colour_valid, 1);
    chk("E_col_after_release", bus.colour_o, 3);
    settle();
    start(1'b1, 4'b0100);
    repeat (5) step();
    chk("F_busy_pre_reset", bus.busy, 1);
    #2 reset = 1'b1; bus.enable = 1'b0;
    #1 chk("F_reset_outputs", {bus.colour_o, bus.colour_valid, bus.invalid_o, bus.timeout_o, bus.busy}, 0);
    @(posedge clk);
    #3 reset = 1'b0;
    pulses = 0;
    repeat (10) begin step(); pulses += int'(bus.colour_valid | bus.invalid_o | bus.timeout_o); end
    chk("F_no_pulse_after_reset", pulses, 0);
    start(1'b1, 4'b0100);
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i == 5) chk("F_cv_e5", bus.colour_valid, 0);
      if (i == 6) chk("F_cv_e6", bus.colour_valid, 1);
      if (i == 6) chk("F_col_e6", bus.colour_o, 2);
    end
    settle();
    start(1'b1, 4'b0010);
    repeat (5) step();
    chk("G_busy_e5", bus.busy, 1);
    set_in(1'b0, 4'b0010);
    step();
    chk("G_idle_e6", bus.busy, 0);
    pulses = 0;
    repeat (8) begin step(); pulses += int'(bus.colour_valid | bus.invalid_o); end
    chk("G_no_pulse", pulses, 0);
    settle();
    for (int n = 0; n < 900; n++) begin
      int r, hold;
      logic [3:0] s;
      r = int'($urandom % 4);
      s = (r == 0) ? 4'd0 : (r < 3) ? 4'(1 << ($urandom % 4)) : 4'($urandom % 16);
      hold = int'($urandom_range(1, (r == 0) ? 30 : 8));
      @(posedge clk);
      #2 bus.enable = ($urandom % 20) != 0; bus.sw = s;
      if ($urandom % 60 == 0) begin
        #1 reset = 1'b1;
        @(posedge clk);
        #3 reset = 1'b0;
      end
      repeat (hold - 1) @(posedge clk);
    end
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
